pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the RISC-V core. It replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. The payload is a flat DATA_W bus packed by the instantiating stage. The block keeps the existing 6-bit stall-vector semantics and adds a valid/ready handshake, a synchronous flush, an optional 1-entry skid buffer and a saturating bubble counter.

---
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic inter-stage pipeline register. It combines the legacy
//            6-bit stall vector with a valid/ready handshake, a synchronous
//            flush and a saturating count of bubbles issued downstream.
//            Define PIPE_SKID_EN to add a 1-entry skid buffer and a
//            registered in_ready.
//            STAGE+1 must be less than STALL_W.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int                DATA_W    = 32,
   parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
   parameter int                STALL_W   = 6,
   parameter int                STAGE     = 2,
   parameter int                CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic [CNT_W-1:0]   bubble_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic              w_stall_up;     // upstream stage stalled
   logic              w_stall_dn;     // this stage (downstream side) stalled
   logic              w_in_fire;
   logic              w_out_acc;
   logic              w_main_free;
   logic              w_load_bubble;
   logic              w_skid_valid;
   logic [DATA_W-1:0] w_skid_data;
   logic              w_unused_stall;

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_bubble_cnt;

   // Only two bits of the stall vector matter to this stage.
   assign w_stall_up     = stall[STAGE];
   assign w_stall_dn     = stall[STAGE+1];
   assign w_unused_stall = ^stall;

   assign w_in_fire   = in_valid && in_ready && !w_stall_up;
   assign w_out_acc   = r_valid && out_ready && !w_stall_dn;
   assign w_main_free = !r_valid || w_out_acc;

   // A bubble is loaded when the main register frees up with nothing to take.
   assign w_load_bubble = w_main_free && !w_skid_valid && !w_in_fire;

`ifdef PIPE_SKID_EN
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;
   logic              w_to_skid;

   // Incoming payload parks in the skid when main is busy or already being
   // refilled from the skid in this cycle.
   assign w_to_skid    = w_in_fire && (r_skid_valid || !w_main_free);
   assign w_skid_valid = r_skid_valid;
   assign w_skid_data  = r_skid_data;
   assign in_ready     = !r_skid_valid;

   // Skid entry: filled on overflow, drained whenever main is free.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_skid_valid <= 1'b0;
         r_skid_data  <= NOP_VALUE;
      end else if (w_to_skid) begin
         r_skid_valid <= 1'b1;
         r_skid_data  <= in_data;
      end else if (w_main_free) begin
         r_skid_valid <= 1'b0;
      end
   end
`else
   // No skid: capacity one, ready follows the main register combinationally.
   assign w_skid_valid = 1'b0;
   assign w_skid_data  = NOP_VALUE;
   assign in_ready     = !r_valid || (out_ready && !w_stall_dn);
`endif

   // Main register: skid first, then fresh input, otherwise a bubble.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= 1'b0;
         r_data  <= NOP_VALUE;
      end else if (w_main_free) begin
         if (w_skid_valid) begin
            r_valid <= 1'b1;
            r_data  <= w_skid_data;
         end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
         end else begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
         end
      end
   end

   // Saturating bubble counter; flush-induced bubbles are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bubble_cnt <= '0;
      end else if (!flush && w_load_bubble && !w_stall_dn &&
                   (r_bubble_cnt != c_cnt_max)) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign out_valid  = r_valid;
   assign out_data   = r_data;
   assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg (STAGE=2,
//            CNT_W=2, RISC-V NOP as bubble payload). Follows PIPE_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam int          DATA_W = 32;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [5:0]        stall;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic [CNT_W-1:0]  bubble_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W    (DATA_W),
      .NOP_VALUE (NOP),
      .STALL_W   (6),
      .STAGE     (2),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .bubble_cnt (bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] exp_sat [5];
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // ---------------- reset ----------------
      rst = 1'b1; stall = '0; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
      tick; tick;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, NOP);
      chk("rst_cnt", 32'(bubble_cnt), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      // ---------------- streaming ----------------
      rst = 1'b0;
      for (int d = 1; d <= 4; d++) begin
         in_data = 32'(d);
         tick;
         chk("stream_data", out_data, 32'(d));
         chk("stream_valid", 32'(out_valid), 32'd1);
      end
      chk("stream_cnt", 32'(bubble_cnt), 32'd0);

      // ---------------- legacy stall ----------------
      in_data = 32'h11;
      tick;
      chk("stall_load", out_data, 32'h11);
      stall = 6'b001100; in_data = 32'h22;
      tick;
      chk("stall_hold1", out_data, 32'h11);
      tick;
      chk("stall_hold2", out_data, 32'h11);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_cnt", 32'(bubble_cnt), 32'd0);
      stall = 6'b000100;
      tick;
      chk("bubble_valid", 32'(out_valid), 32'd0);
      chk("bubble_data", out_data, NOP);
      chk("bubble_cnt", 32'(bubble_cnt), 32'd1);
      stall = 6'b000000; in_data = 32'h33;
      tick;
      chk("resume_data", out_data, 32'h33);
      chk("resume_cnt", 32'(bubble_cnt), 32'd1);

      // ---------------- backpressure ----------------
      in_data = 32'hA;
      tick;
      chk("bp_load_a", out_data, 32'hA);
      out_ready = 1'b0; in_data = 32'hB;
`ifdef PIPE_SKID_EN
      #1;
      chk("bp_ready_pre", 32'(in_ready), 32'd1);
      tick;
      chk("bp_hold_a1", out_data, 32'hA);
      chk("bp_skid_full", 32'(in_ready), 32'd0);
      in_data = 32'hC;
      tick;
      chk("bp_hold_a2", out_data, 32'hA);
      tick;
      chk("bp_hold_a3", out_data, 32'hA);
      chk("bp_ready_blk", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick;
      chk("bp_out_b", out_data, 32'hB);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      tick;
      chk("bp_out_c", out_data, 32'hC);
`else
      #1;
      chk("bp_ready_blk", 32'(in_ready), 32'd0);
      tick;
      chk("bp_hold_a1", out_data, 32'hA);
      tick;
      chk("bp_hold_a2", out_data, 32'hA);
      tick;
      chk("bp_hold_a3", out_data, 32'hA);
      out_ready = 1'b1;
      #1;
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      tick;
      chk("bp_out_b", out_data, 32'hB);
      in_data = 32'hC;
      tick;
      chk("bp_out_c", out_data, 32'hC);
`endif
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_cnt", 32'(bubble_cnt), 32'd1);

      // ---------------- flush ----------------
      in_data = 32'h5;
      tick;
      chk("fl_main5", out_data, 32'h5);
`ifdef PIPE_SKID_EN
      out_ready = 1'b0; in_data = 32'h6;
      tick;
      chk("fl_skid6_main", out_data, 32'h5);
      chk("fl_skid6_ready", 32'(in_ready), 32'd0);
`endif
      flush = 1'b1; in_data = 32'h7;
      tick;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_data", out_data, NOP);
      chk("fl_ready", 32'(in_ready), 32'd1);
      chk("fl_cnt", 32'(bubble_cnt), 32'd1);
      // Downstream stalled: an empty main would pull any surviving skid entry.
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stall = 6'b001000;
      tick;
      chk("fl_empty_valid", 32'(out_valid), 32'd0);
      chk("fl_empty_cnt", 32'(bubble_cnt), 32'd1);

      // ---------------- saturation ----------------
      rst = 1'b1; stall = '0;
      tick;
      chk("sat_rst_cnt", 32'(bubble_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("sat_cnt", 32'(bubble_cnt), 32'(exp_sat[i]));
      end

      // ---------------- reset mid-transfer ----------------
      in_valid = 1'b1; in_data = 32'h44;
      tick;
      chk("mid_load", out_data, 32'h44);
      rst = 1'b1;
      tick;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", out_data, NOP);
      chk("mid_rst_cnt", 32'(bubble_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
